// File: rtl/stack_seq.sv
// SM83 PUSH rr / POP rr sequencer: owns SP, moves 16-bit register pairs to and
// from the byte memory bus over a req/ready handshake, with a per-access timeout.
module stack_seq #(
  parameter logic [15:0] SP_RESET = 16'hFFFE,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  rp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] sp,
  input  logic        sp_we,
  input  logic [15:0] sp_wd,
  output logic [1:0]  rf_rda_adr,
  input  logic [15:0] rf_rda,
  output logic        rf_wea,
  output logic [1:0]  rf_waa,
  output logic [15:0] rf_wda,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, WB, FIN
  } state_e;

  state_e      state_q;
  logic [15:0] sp_q;
  logic [1:0]  rp_q;
  logic [7:0]  byte_q;
  logic [15:0] wait_q;
  logic        busy_q, done_q, err_q;
  logic        rf_wea_q;
  logic [1:0]  rf_waa_q;
  logic [15:0] rf_wda_q;
  logic        mem_req_q, mem_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        tmo_d;

  // Fires on the TIMEOUT-th consecutive stalled cycle of the current access.
  always_comb begin
    tmo_d = 1'b0;
    if ((TIMEOUT != 0) && mem_req_q && !mem_ready && (wait_q == 16'(TIMEOUT - 1)))
      tmo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      rp_q        <= '0;
      byte_q      <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rf_wea_q    <= 1'b0;
      rf_waa_q    <= '0;
      rf_wda_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rf_wea_q <= 1'b0;
      if (tmo_d) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        err_q     <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (sp_we) begin
              sp_q <= sp_wd;
            end else if (start) begin
              if (rp == 2'd3) begin
                err_q <= 1'b1;
              end else begin
                rp_q      <= rp;
                wait_q    <= '0;
                busy_q    <= 1'b1;
                mem_req_q <= 1'b1;
                if (!op) begin
                  state_q     <= PUSH_HI;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= sp_q - 16'd1;
                  mem_wdata_q <= rf_rda[15:8];
                  byte_q      <= rf_rda[7:0];
                end else begin
                  state_q    <= POP_LO;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= sp_q;
                end
              end
            end
          end
          PUSH_HI: begin
            if (mem_ready) begin
              state_q     <= PUSH_LO;
              mem_addr_q  <= sp_q - 16'd2;
              mem_wdata_q <= byte_q;
              wait_q      <= '0;
            end else begin
              wait_q <= wait_q + 16'd1;
            end
          end
          PUSH_LO: begin
            if (mem_ready) begin
              state_q   <= FIN;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              wait_q <= wait_q + 16'd1;
            end
          end
          FIN: begin
            sp_q    <= sp_q - 16'd2;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          POP_LO: begin
            if (mem_ready) begin
              state_q    <= POP_HI;
              byte_q     <= mem_rdata;
              mem_addr_q <= sp_q + 16'd1;
              wait_q     <= '0;
            end else begin
              wait_q <= wait_q + 16'd1;
            end
          end
          POP_HI: begin
            if (mem_ready) begin
              state_q   <= WB;
              mem_req_q <= 1'b0;
              rf_wea_q  <= 1'b1;
              rf_waa_q  <= rp_q;
              rf_wda_q  <= {mem_rdata, byte_q};
              done_q    <= 1'b1;
            end else begin
              wait_q <= wait_q + 16'd1;
            end
          end
          WB: begin
            sp_q    <= sp_q + 16'd2;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rf_rda_adr = (state_q == IDLE) ? rp : rp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sp         = sp_q;
  assign rf_wea     = rf_wea_q;
  assign rf_waa     = rf_waa_q;
  assign rf_wda     = rf_wda_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: byte memory + regfile responders around the DUT, checked
// against a stack model (SP, memory image, register pairs) kept here.
module tb_stack_seq;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, op = 1'b0, sp_we = 1'b0;
  logic [1:0]  rp = 2'd0;
  logic [15:0] sp_wd = 16'h0;
  logic        busy, done, err, rf_wea, mem_req, mem_we, mem_ready;
  logic [15:0] sp, rf_rda, rf_wda, mem_addr;
  logic [1:0]  rf_rda_adr, rf_waa;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  stack_seq #(.SP_RESET(16'hFFFE), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rp(rp),
    .busy(busy), .done(done), .err(err), .sp(sp),
    .sp_we(sp_we), .sp_wd(sp_wd),
    .rf_rda_adr(rf_rda_adr), .rf_rda(rf_rda),
    .rf_wea(rf_wea), .rf_waa(rf_waa), .rf_wda(rf_wda),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} acc_t;

  acc_t        acc_q[$];
  logic [7:0]  mem   [0:65535];
  logic [7:0]  mem_m [0:65535];
  logic [15:0] rf_tb [0:3];
  logic [15:0] rf_m  [0:3];
  logic [15:0] sp_m;
  int          rcnt = 0, wait_n = 0;
  logic        ready_en = 1'b1;
  int          n_chk = 0, n_fail = 0;
  int          wea_cnt = 0, req_cnt = 0, stab_bad = 0;
  logic [1:0]  last_waa = 2'd0;
  logic [15:0] last_wda = 16'h0;
  logic        pend = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'h0;
  logic [7:0]  p_wd = 8'h0;

  assign rf_rda    = rf_tb[rf_rda_adr];
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_req && ready_en && (rcnt >= wait_n);

  // Memory/regfile responders and bus-stability monitor.
  always @(posedge clk) begin
    if (mem_req) req_cnt <= req_cnt + 1;
    if (mem_req && !mem_ready) rcnt <= rcnt + 1; else rcnt <= 0;
    if (mem_req && mem_ready) begin
      acc_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
    if (rf_wea) begin
      rf_tb[rf_waa] = rf_wda;
      wea_cnt  <= wea_cnt + 1;
      last_waa <= rf_waa;
      last_wda <= rf_wda;
    end
    if (pend && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd))
      stab_bad <= stab_bad + 1;
    pend   <= mem_req && !mem_ready;
    p_addr <= mem_addr;
    p_we   <= mem_we;
    p_wd   <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sp(input logic [15:0] v);
    sp_we = 1'b1; sp_wd = v;
    tick();
    sp_we = 1'b0;
    sp_m = v;
  endtask

  // Issues one op and waits (bounded) for done/err; returns cycle indices relative
  // to the accept cycle T0, plus SP and the done|err level one cycle later.
  task automatic run_op(input logic o, input logic [1:0] r, output int dcyc, output int ecyc,
                        output logic [15:0] sp_after, output logic tail, output int abase,
                        output int nwea, output int nreq);
    int wb, rb;
    abase = acc_q.size(); wb = wea_cnt; rb = req_cnt;
    dcyc = -1; ecyc = -1;
    op = o; rp = r; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (done === 1'b1 && dcyc < 0) dcyc = k;
      if (err === 1'b1 && ecyc < 0) ecyc = k;
      if (dcyc >= 0 || ecyc >= 0) break;
      tick();
    end
    tick();
    sp_after = sp; tail = done | err;
    nwea = wea_cnt - wb; nreq = req_cnt - rb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (sp !== 16'hFFFE) begin n_fail++; $display("FAIL reset_sp: got %h expected fffe", sp); end
    n_chk++; if ({busy, done, err, mem_req, mem_we, rf_wea} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, err, mem_req, mem_we, rf_wea}); end
    n_chk++; if ({mem_addr, mem_wdata, rf_wda, rf_waa} !== 42'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rf_wda, rf_waa}); end
    rst_n = 1'b1;
    tick();
    sp_m = 16'hFFFE;
  endtask

  task automatic test_push_bc();
    int d, e, ab, nw, nr; logic [15:0] spa; logic t;
    rf_tb[0] = 16'h1234; rf_m[0] = 16'h1234; wait_n = 0;
    run_op(1'b0, 2'd0, d, e, spa, t, ab, nw, nr);
    n_chk++; if (d !== 3) begin n_fail++; $display("FAIL push_bc_done_cycle: got %0d expected 3", d); end
    n_chk++; if (acc_q.size() - ab !== 2 || acc_q[ab] !== {1'b1, 16'hFFFD, 8'h12} || acc_q[ab+1] !== {1'b1, 16'hFFFC, 8'h34}) begin
      n_fail++; $display("FAIL push_bc_writes: got n=%0d %h %h expected 1fffd12 1fffc34", acc_q.size() - ab, acc_q[ab], acc_q[ab+1]); end
    n_chk++; if (spa !== 16'hFFFC) begin n_fail++; $display("FAIL push_bc_sp: got %h expected fffc", spa); end
    n_chk++; if (nr !== 2 || nw !== 0 || t !== 1'b0) begin
      n_fail++; $display("FAIL push_bc_side: got req=%0d wea=%0d tail=%b expected 2 0 0", nr, nw, t); end
    mem_m[16'hFFFD] = 8'h12; mem_m[16'hFFFC] = 8'h34; sp_m = 16'hFFFC;
  endtask

  task automatic test_pop_hl();
    int d, e, ab, nw, nr; logic [15:0] spa; logic t;
    mem[16'hFFFC] = 8'hCD; mem[16'hFFFD] = 8'hAB; mem_m[16'hFFFC] = 8'hCD; mem_m[16'hFFFD] = 8'hAB;
    run_op(1'b1, 2'd2, d, e, spa, t, ab, nw, nr);
    n_chk++; if (d !== 3) begin n_fail++; $display("FAIL pop_hl_done_cycle: got %0d expected 3", d); end
    n_chk++; if (nw !== 1 || last_waa !== 2'd2 || last_wda !== 16'hABCD) begin
      n_fail++; $display("FAIL pop_hl_wb: got n=%0d waa=%0d wda=%h expected 1 2 abcd", nw, last_waa, last_wda); end
    n_chk++; if (acc_q.size() - ab !== 2 || acc_q[ab] !== {1'b0, 16'hFFFC, 8'hCD} || acc_q[ab+1] !== {1'b0, 16'hFFFD, 8'hAB}) begin
      n_fail++; $display("FAIL pop_hl_reads: got %h %h expected 0fffccd 0fffdab", acc_q[ab], acc_q[ab+1]); end
    n_chk++; if (spa !== 16'hFFFE) begin n_fail++; $display("FAIL pop_hl_sp: got %h expected fffe", spa); end
    rf_m[2] = 16'hABCD; sp_m = 16'hFFFE;
  endtask

  task automatic test_wrap();
    int d, e, ab, nw, nr; logic [15:0] spa, v; logic t;
    load_sp(16'h0001);
    n_chk++; if (sp !== 16'h0001) begin n_fail++; $display("FAIL wrap_sp_load: got %h expected 0001", sp); end
    v = 16'($urandom); rf_tb[1] = v; rf_m[1] = v;
    run_op(1'b0, 2'd1, d, e, spa, t, ab, nw, nr);
    n_chk++; if (acc_q.size() - ab !== 2 || acc_q[ab] !== {1'b1, 16'h0000, v[15:8]} || acc_q[ab+1] !== {1'b1, 16'hFFFF, v[7:0]}) begin
      n_fail++; $display("FAIL wrap_push_addrs: got %h %h expected 10000%h 1ffff%h", acc_q[ab], acc_q[ab+1], v[15:8], v[7:0]); end
    n_chk++; if (spa !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_push_sp: got %h expected ffff", spa); end
    mem_m[16'h0000] = v[15:8]; mem_m[16'hFFFF] = v[7:0];
    run_op(1'b1, 2'd2, d, e, spa, t, ab, nw, nr);
    n_chk++; if (acc_q.size() - ab !== 2 || acc_q[ab].addr !== 16'hFFFF || acc_q[ab+1].addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_pop_addrs: got %h %h expected ffff 0000", acc_q[ab].addr, acc_q[ab+1].addr); end
    n_chk++; if (spa !== 16'h0001 || last_wda !== v || nw !== 1) begin
      n_fail++; $display("FAIL wrap_pop_result: got sp=%h wda=%h n=%0d expected 0001 %h 1", spa, last_wda, nw, v); end
    rf_m[2] = v; sp_m = 16'h0001;
  endtask

  task automatic test_wait_states();
    int d, e, ab, nw, nr, sb; logic [15:0] spa, v; logic t;
    wait_n = 3; sb = stab_bad; load_sp(16'h8000);
    v = rf_m[0];
    run_op(1'b0, 2'd0, d, e, spa, t, ab, nw, nr);
    n_chk++; if (d !== 9) begin n_fail++; $display("FAIL wait_push_done_cycle: got %0d expected 9", d); end
    n_chk++; if (nr !== 8 || spa !== 16'h7FFE) begin
      n_fail++; $display("FAIL wait_push_req_sp: got req=%0d sp=%h expected 8 7ffe", nr, spa); end
    mem_m[16'h7FFF] = v[15:8]; mem_m[16'h7FFE] = v[7:0];
    run_op(1'b1, 2'd1, d, e, spa, t, ab, nw, nr);
    n_chk++; if (d !== 9 || last_wda !== v || last_waa !== 2'd1) begin
      n_fail++; $display("FAIL wait_pop: got cyc=%0d wda=%h waa=%0d expected 9 %h 1", d, last_wda, last_waa, v); end
    n_chk++; if (stab_bad !== sb) begin n_fail++; $display("FAIL wait_bus_stable: got %0d changes expected 0", stab_bad - sb); end
    rf_m[1] = v; sp_m = 16'h8000; wait_n = 0;
  endtask

  task automatic test_timeout();
    int d, e, ab, nw, nr; logic [15:0] spa; logic t;
    ready_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_op(i[0], 2'd1, d, e, spa, t, ab, nw, nr);
      n_chk++; if (e !== 17 || d !== -1) begin
        n_fail++; $display("FAIL timeout_err_cycle: got err=%0d done=%0d expected 17 -1", e, d); end
      n_chk++; if (busy !== 1'b0 || t !== 1'b0 || spa !== sp_m || nw !== 0 || acc_q.size() !== ab) begin
        n_fail++; $display("FAIL timeout_abort: got busy=%b tail=%b sp=%h wea=%0d acc=%0d expected 0 0 %h 0 0",
                           busy, t, spa, nw, acc_q.size() - ab, sp_m); end
    end
    ready_en = 1'b1;
  endtask

  task automatic test_illegal();
    int d, e, ab, nw, nr, rb; logic [15:0] spa, v; logic t;
    run_op(1'b0, 2'd3, d, e, spa, t, ab, nw, nr);
    n_chk++; if (e !== 1 || d !== -1 || nr !== 0 || spa !== sp_m || t !== 1'b0) begin
      n_fail++; $display("FAIL illegal_rp: got err=%0d done=%0d req=%0d sp=%h tail=%b expected 1 -1 0 %h 0", e, d, nr, spa, t, sp_m); end
    v = 16'($urandom); rb = req_cnt;
    sp_we = 1'b1; sp_wd = v; start = 1'b1; op = 1'b0; rp = 2'd0;
    tick();
    sp_we = 1'b0; start = 1'b0;
    n_chk++; if (sp !== v || busy !== 1'b0) begin
      n_fail++; $display("FAIL spwe_start: got sp=%h busy=%b expected %h 0", sp, busy, v); end
    repeat (4) tick();
    n_chk++; if (req_cnt !== rb) begin n_fail++; $display("FAIL spwe_start_noop: got %0d reqs expected 0", req_cnt - rb); end
    sp_m = v;
  endtask

  task automatic test_busy_ignore();
    int rb, dc; logic [15:0] s0;
    s0 = sp_m; rb = req_cnt; dc = -1; wait_n = 1;
    op = 1'b0; rp = 2'd0; start = 1'b1;
    tick();
    sp_we = 1'b1; sp_wd = 16'h1234; op = 1'b1;
    repeat (3) tick();
    sp_we = 1'b0; start = 1'b0;
    for (int k = 4; k <= 40; k++) begin
      if (done === 1'b1) begin dc = k; break; end
      tick();
    end
    tick();
    n_chk++; if (dc !== 5 || sp !== s0 - 16'd2 || req_cnt - rb !== 4) begin
      n_fail++; $display("FAIL busy_ignore: got done=%0d sp=%h req=%0d expected 5 %h 4", dc, sp, req_cnt - rb, s0 - 16'd2); end
    mem_m[s0 - 16'd1] = rf_m[0][15:8]; mem_m[s0 - 16'd2] = rf_m[0][7:0];
    sp_m = s0 - 16'd2; wait_n = 0;
  endtask

  task automatic test_reset_mid();
    int wb;
    load_sp(16'h4000); wait_n = 3;
    op = 1'b1; rp = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wb = wea_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0 || busy !== 1'b0 || sp !== 16'hFFFE) begin
      n_fail++; $display("FAIL reset_mid: got req=%b busy=%b sp=%h expected 0 0 fffe", mem_req, busy, sp); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    n_chk++; if (wea_cnt !== wb || rf_tb[0] !== rf_m[0]) begin
      n_fail++; $display("FAIL reset_mid_nowrite: got wea=%0d rf=%h expected 0 %h", wea_cnt - wb, rf_tb[0], rf_m[0]); end
    sp_m = 16'hFFFE; wait_n = 0;
  endtask

  task automatic test_random();
    int d, e, ab, nw, nr, w; logic [15:0] spa, v, a1; logic t, o; logic [1:0] r;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3) == 0) begin
        v = 16'($urandom); load_sp(v);
        n_chk++; if (sp !== v) begin n_fail++; $display("FAIL rnd_sp_load: got %h expected %h", sp, v); end
      end
      o = 1'($urandom_range(1)); r = 2'($urandom_range(3)); w = $urandom_range(2); wait_n = w;
      a1 = sp_m + 16'd1;
      run_op(o, r, d, e, spa, t, ab, nw, nr);
      if (r == 2'd3) begin
        n_chk++; if (e !== 1 || nr !== 0 || spa !== sp_m) begin
          n_fail++; $display("FAIL rnd_illegal: got err=%0d req=%0d sp=%h expected 1 0 %h", e, nr, spa, sp_m); end
      end else if (!o) begin
        v = rf_m[r];
        n_chk++; if (d !== 2*w + 3 || e !== -1 || acc_q.size() - ab !== 2 || spa !== sp_m - 16'd2) begin
          n_fail++; $display("FAIL rnd_push_timing: got cyc=%0d err=%0d n=%0d sp=%h expected %0d -1 2 %h",
                             d, e, acc_q.size() - ab, spa, 2*w + 3, sp_m - 16'd2); end
        else begin
          n_chk++; if (acc_q[ab] !== {1'b1, sp_m - 16'd1, v[15:8]} || acc_q[ab+1] !== {1'b1, sp_m - 16'd2, v[7:0]}) begin
            n_fail++; $display("FAIL rnd_push_data: got %h %h expected %h %h", acc_q[ab], acc_q[ab+1],
                               {1'b1, sp_m - 16'd1, v[15:8]}, {1'b1, sp_m - 16'd2, v[7:0]}); end
        end
        mem_m[sp_m - 16'd1] = v[15:8]; mem_m[sp_m - 16'd2] = v[7:0]; sp_m = sp_m - 16'd2;
      end else begin
        v = {mem_m[a1], mem_m[sp_m]};
        n_chk++; if (d !== 2*w + 3 || nw !== 1 || last_waa !== r || last_wda !== v || spa !== sp_m + 16'd2) begin
          n_fail++; $display("FAIL rnd_pop: got cyc=%0d wea=%0d waa=%0d wda=%h sp=%h expected %0d 1 %0d %h %h",
                             d, nw, last_waa, last_wda, spa, 2*w + 3, r, v, sp_m + 16'd2); end
        rf_m[r] = v; sp_m = sp_m + 16'd2;
      end
    end
    wait_n = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      mem_m[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      rf_tb[i] = 16'($urandom);
      rf_m[i] = rf_tb[i];
    end
    test_reset();
    test_push_bc();
    test_pop_hl();
    test_wrap();
    test_wait_states();
    test_timeout();
    test_illegal();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1);
  end

endmodule
